// File: rtl/man_pkg.sv
// Shared state codes, output bundle and the pure next-state / output-decode functions.
// MAN_TURN_IN_PLACE_EN: when defined, turning is also allowed in START.
package man_pkg;

   localparam logic [1:0] ST_OFF   = 2'b00;
   localparam logic [1:0] ST_IDLE  = 2'b01;
   localparam logic [1:0] ST_START = 2'b10;
   localparam logic [1:0] ST_MOVE  = 2'b11;

   typedef struct packed {
      logic power_break;
      logic move_forward;
      logic move_backward;
      logic turn_left;
      logic turn_right;
   } man_out_t;

   // Brake is tested first in every live state so it dominates all other pedals.
   function automatic logic [1:0] next_state(input logic [1:0] cur,
                                             input logic brake,
                                             input logic clutch,
                                             input logic throttle,
                                             input logic gear_err);
      logic [1:0] nxt;
      nxt = cur;
      case (cur)
         ST_OFF:   nxt = ST_OFF;
         ST_IDLE: begin
            if (brake)                  nxt = ST_IDLE;
            else if (throttle & clutch) nxt = ST_START;
            else if (throttle)          nxt = ST_OFF;
            else                        nxt = ST_IDLE;
         end
         ST_START: begin
            if (brake)                  nxt = ST_IDLE;
            else if (throttle & ~clutch) nxt = ST_MOVE;
            else                        nxt = ST_START;
         end
         default: begin
            if (brake)                  nxt = ST_IDLE;
            else if (gear_err)          nxt = ST_OFF;
            else if (clutch | ~throttle) nxt = ST_START;
            else                        nxt = ST_MOVE;
         end
      endcase
      return nxt;
   endfunction

   function automatic man_out_t decode_out(input logic [1:0] nxt,
                                           input logic reverse,
                                           input logic left,
                                           input logic right);
      man_out_t o;
      logic     turn_ok;
`ifdef MAN_TURN_IN_PLACE_EN
      turn_ok = (nxt == ST_MOVE) | (nxt == ST_START);
`else
      turn_ok = (nxt == ST_MOVE);
`endif
      o.power_break   = (nxt == ST_OFF);
      o.move_forward  = (nxt == ST_MOVE) & ~reverse;
      o.move_backward = (nxt == ST_MOVE) & reverse;
      o.turn_left     = left & ~right & turn_ok;
      o.turn_right    = right & ~left & turn_ok;
      return o;
   endfunction

endpackage

// File: rtl/man_if.sv
// Driver controls, current state and registered commands of the manual-driving block.
interface man_if;

   logic [1:0] state_cur;
   logic       enable;
   logic       reverse;
   logic       brake;
   logic       clutch;
   logic       throttle;
   logic       left;
   logic       right;
   logic       power_break;
   logic       move_forward;
   logic       move_backward;
   logic       turn_left;
   logic       turn_right;
   logic [1:0] state_next;

   modport master (
      output state_cur, enable, reverse, brake, clutch, throttle, left, right,
      input  power_break, move_forward, move_backward, turn_left, turn_right, state_next
   );

   modport slave (
      input  state_cur, enable, reverse, brake, clutch, throttle, left, right,
      output power_break, move_forward, move_backward, turn_left, turn_right, state_next
   );

endinterface

// File: rtl/man_next_state.sv
// Combinational next driving state and command decode, including the gear-mismatch check.
module man_next_state
   import man_pkg::*;
(
   input  logic [1:0] state_cur,
   input  logic       reverse,
   input  logic       brake,
   input  logic       clutch,
   input  logic       throttle,
   input  logic       left,
   input  logic       right,
   input  logic       gear_q,
   output logic [1:0] nxt,
   output man_out_t   outs
);

   logic gear_err;

   // Shifting direction while moving without the clutch stalls the engine.
   assign gear_err = (state_cur == ST_MOVE) & ~clutch & (reverse != gear_q);
   assign nxt      = next_state(state_cur, brake, clutch, throttle, gear_err);
   assign outs     = decode_out(nxt, reverse, left, right);

endmodule

// File: rtl/man.sv
// Manual-driving controller: registers next state, motion/turn commands and the latched gear.
// Optional feature macro: MAN_TURN_IN_PLACE_EN (handled in man_pkg::decode_out).
module man
   import man_pkg::*;
(
   input  logic clk,
   input  logic rst,
   man_if.slave bus
);

   logic [1:0] nxt;
   man_out_t   outs;
   logic [1:0] state_q;
   man_out_t   outs_q;
   logic       gear_q;

   man_next_state u_next (
      .state_cur (bus.state_cur),
      .reverse   (bus.reverse),
      .brake     (bus.brake),
      .clutch    (bus.clutch),
      .throttle  (bus.throttle),
      .left      (bus.left),
      .right     (bus.right),
      .gear_q    (gear_q),
      .nxt       (nxt),
      .outs      (outs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         outs_q  <= '0;
         gear_q  <= 1'b0;
      end else if (!bus.enable) begin
         state_q <= bus.state_cur;
         outs_q  <= '0;
      end else begin
         state_q <= nxt;
         outs_q  <= outs;
         // Gear only follows the lever when it can legally change.
         if (bus.clutch || (bus.state_cur != ST_MOVE))
            gear_q <= bus.reverse;
      end
   end

   assign bus.state_next    = state_q;
   assign bus.power_break   = outs_q.power_break;
   assign bus.move_forward  = outs_q.move_forward;
   assign bus.move_backward = outs_q.move_backward;
   assign bus.turn_left     = outs_q.turn_left;
   assign bus.turn_right    = outs_q.turn_right;

endmodule

// File: tb/tb_man.sv
// Directed bench for man: vector tables of {state, rev/brk/clu/thr, left, right, enable, expected}.
module tb_man;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   man_if bus ();

   man dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // {state_next, power_break, move_forward, move_backward, turn_left, turn_right}
   function automatic logic [6:0] snap();
      return {bus.state_next, bus.power_break, bus.move_forward, bus.move_backward,
              bus.turn_left, bus.turn_right};
   endfunction

   // vector: [16:15] state_cur, [14:11] rev,brk,clu,thr, [10] left, [9] right, [8] enable, [6:0] expected
   task automatic step(input logic [16:0] v);
      @(negedge clk);
      bus.state_cur = v[16:15];
      {bus.reverse, bus.brake, bus.clutch, bus.throttle} = v[14:11];
      bus.left   = v[10];
      bus.right  = v[9];
      bus.enable = v[8];
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (snap() !== 7'b00_00000) begin
         n_fail++;
         $display("FAIL reset got=%b exp=%b", snap(), 7'b00_00000);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_start_move();
      logic [16:0] v [5];
      v = '{17'b01_1011_001_0_1000000, 17'b10_0011_001_0_1000000, 17'b10_0000_001_0_1000000,
            17'b10_0001_001_0_1101000, 17'b01_0000_001_0_0100000};
      for (int i = 0; i < 5; i++) begin
         step(v[i]);
         n_chk++;
         if (snap() !== v[i][6:0]) begin
            n_fail++;
            $display("FAIL start_move[%0d] got=%b exp=%b", i, snap(), v[i][6:0]);
         end
      end
   endtask

   task automatic test_brake_stall();
      logic [16:0] v [8];
      v = '{17'b11_0100_001_0_0100000, 17'b01_0101_001_0_0100000, 17'b01_0001_001_0_0010000,
            17'b01_0011_001_0_1000000, 17'b10_1011_001_0_1000000, 17'b10_1111_001_0_0100000,
            17'b01_1001_001_0_0010000, 17'b00_0011_001_0_0010000};
      for (int i = 0; i < 8; i++) begin
         step(v[i]);
         n_chk++;
         if (snap() !== v[i][6:0]) begin
            n_fail++;
            $display("FAIL brake_stall[%0d] got=%b exp=%b", i, snap(), v[i][6:0]);
         end
      end
   endtask

   task automatic test_gear();
      logic [16:0] v [6];
      v = '{17'b10_0001_001_0_1101000, 17'b11_0001_001_0_1101000, 17'b11_1001_001_0_0010000,
            17'b11_1011_001_0_1000000, 17'b10_1001_001_0_1100100, 17'b11_1001_001_0_1100100};
      for (int i = 0; i < 6; i++) begin
         step(v[i]);
         n_chk++;
         if (snap() !== v[i][6:0]) begin
            n_fail++;
            $display("FAIL gear[%0d] got=%b exp=%b", i, snap(), v[i][6:0]);
         end
      end
   endtask

   task automatic test_turn_enable();
      logic [16:0] v [9];
      v = '{17'b10_0001_101_0_1101010, 17'b11_0001_101_0_1101010, 17'b11_0001_111_0_1101000,
            17'b11_0001_011_0_1101001, 17'b11_0000_101_0_1000000, 17'b11_0001_100_0_1100000,
            17'b01_0011_110_0_0100000, 17'b11_1001_010_0_1100000, 17'b11_1001_001_0_0010000};
      // first steps re-latch gear 0; disabled steps must hold it so the last step stalls
      for (int i = 0; i < 9; i++) begin
         step(v[i]);
         n_chk++;
         if (snap() !== v[i][6:0]) begin
            n_fail++;
            $display("FAIL turn_enable[%0d] got=%b exp=%b", i, snap(), v[i][6:0]);
         end
      end
   endtask

   task automatic test_turn_in_place();
      logic [6:0] exp;
`ifdef MAN_TURN_IN_PLACE_EN
      exp = 7'b10_00001;
`else
      exp = 7'b10_00000;
`endif
      step(17'b10_0000_011_0_0000000);
      n_chk++;
      if (snap() !== exp) begin
         n_fail++;
         $display("FAIL turn_in_place got=%b exp=%b", snap(), exp);
      end
      step(17'b01_0100_011_0_0000000);
      n_chk++;
      if (snap() !== 7'b01_00000) begin
         n_fail++;
         $display("FAIL turn_idle got=%b exp=%b", snap(), 7'b01_00000);
      end
   endtask

   task automatic test_reset_mid();
      step(17'b10_0001_101_0_0000000);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if (snap() !== 7'b00_00000) begin
         n_fail++;
         $display("FAIL reset_mid_move got=%b exp=%b", snap(), 7'b00_00000);
      end
      @(negedge clk);
      rst = 1'b0;
      step(17'b10_0000_000_0_0000000);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if (snap() !== 7'b00_00000) begin
         n_fail++;
         $display("FAIL reset_mid_disabled got=%b exp=%b", snap(), 7'b00_00000);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.state_cur = 2'b00;
      bus.enable    = 1'b0;
      bus.reverse   = 1'b0;
      bus.brake     = 1'b0;
      bus.clutch    = 1'b0;
      bus.throttle  = 1'b0;
      bus.left      = 1'b0;
      bus.right     = 1'b0;
      test_reset();
      test_start_move();
      test_brake_stall();
      test_gear();
      test_turn_enable();
      test_turn_in_place();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
